// File: rtl/scan_chain_ctrl.sv
// Scan-chain initiator: shift a pattern in, capture, unload and compare; result is held until RSP_READY.
// Response appears 2*CHAIN_LEN+CAPTURE_CYC edges after acceptance; PAT_READY stays low until the response is taken.
module scan_chain_ctrl #(
  parameter int   CHAIN_LEN   = 8,
  parameter int   CAPTURE_CYC = 1,
  parameter logic FILL        = 1'b0,
  parameter int   CNT_W       = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 PAT_VALID,
  output logic                 PAT_READY,
  input  logic [CHAIN_LEN-1:0] PAT_DATA,
  input  logic [CHAIN_LEN-1:0] EXP_DATA,
  output logic                 SE,
  output logic                 SI,
  input  logic                 SO,
  output logic                 RSP_VALID,
  input  logic                 RSP_READY,
  output logic [CHAIN_LEN-1:0] RSP_DATA,
  output logic                 RSP_MISMATCH,
  output logic [CNT_W-1:0]     ERR_CNT,
  output logic                 BUSY
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int KW = $clog2(CAPTURE_CYC + 1);

  typedef enum logic [2:0] {IDLE, SHIFT, CAPTURE, UNLOAD, RESP} state_t;

  state_t               state;
  logic [CHAIN_LEN-2:0] pat_sr;
  logic [CHAIN_LEN-1:0] exp_q;
  logic [CW-1:0]        cnt;
  logic [KW-1:0]        cap_cnt;
  logic [CHAIN_LEN-1:0] rsp_next;

  // SO carries the flop nearest the chain end first, so it lands in the MSB after a full unload
  assign rsp_next  = {RSP_DATA[CHAIN_LEN-2:0], SO};
  assign PAT_READY = (state == IDLE);
  assign BUSY      = (state != IDLE);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      SE           <= 1'b0;
      SI           <= 1'b0;
      RSP_VALID    <= 1'b0;
      RSP_DATA     <= '0;
      RSP_MISMATCH <= 1'b0;
      ERR_CNT      <= '0;
      cnt          <= '0;
      cap_cnt      <= '0;
      pat_sr       <= '0;
      exp_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PAT_VALID) begin
            pat_sr <= PAT_DATA[CHAIN_LEN-2:0];
            exp_q  <= EXP_DATA;
            SE     <= 1'b1;
            SI     <= PAT_DATA[CHAIN_LEN-1];
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          SI     <= pat_sr[CHAIN_LEN-2];
          pat_sr <= pat_sr << 1;
          if (cnt == CW'(CHAIN_LEN - 1)) begin
            SE      <= 1'b0;
            cnt     <= '0;
            cap_cnt <= '0;
            state   <= CAPTURE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        CAPTURE: begin
          if (cap_cnt == KW'(CAPTURE_CYC - 1)) begin
            SE    <= 1'b1;
            SI    <= FILL;
            state <= UNLOAD;
          end else begin
            cap_cnt <= cap_cnt + 1'b1;
          end
        end
        UNLOAD: begin
          RSP_DATA <= rsp_next;
          if (cnt == CW'(CHAIN_LEN - 1)) begin
            SE           <= 1'b0;
            RSP_VALID    <= 1'b1;
            RSP_MISMATCH <= |(rsp_next ^ exp_q);
            cnt          <= '0;
            state        <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP: begin
          if (RSP_READY) begin
            RSP_VALID <= 1'b0;
            // an X mismatch flag fails this test, so the counter holds
            if (RSP_MISMATCH && (ERR_CNT != '1))
              ERR_CNT <= ERR_CNT + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Randomized scoreboard bench for scan_chain_ctrl driving a chain whose functional D is ~Q.
module tb_scan_chain_ctrl;

  localparam int   N     = 8;
  localparam int   C     = 1;
  localparam int   CW    = 2;
  localparam logic FILLV = 1'b0;
  localparam int   T     = 2 * N + C + 1;
  localparam int   ERR_MAX = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST, PAT_VALID, PAT_READY, SE, SI, SO;
  logic          RSP_VALID, RSP_READY, RSP_MISMATCH, BUSY;
  logic [N-1:0]  PAT_DATA, EXP_DATA, RSP_DATA;
  logic [CW-1:0] ERR_CNT;
  logic [N-1:0]  chain = '0;

  int vectors = 0;
  int misc    = 0;
  int cyc     = 0;
  int n_pushed = 0;
  int n_done   = 0;
  int model_err = 0;

  typedef struct {
    logic [N-1:0]  rsp;
    logic          mm;
    logic [CW-1:0] err;
    int            hold;
    int            t0;
  } item_t;
  item_t sb[$];

  scan_chain_ctrl #(.CHAIN_LEN(N), .CAPTURE_CYC(C), .FILL(FILLV), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .PAT_VALID(PAT_VALID), .PAT_READY(PAT_READY),
    .PAT_DATA(PAT_DATA), .EXP_DATA(EXP_DATA), .SE(SE), .SI(SI), .SO(SO),
    .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_DATA(RSP_DATA),
    .RSP_MISMATCH(RSP_MISMATCH), .ERR_CNT(ERR_CNT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // chain under test: shifts when SE=1, otherwise every flop loads its own inverse
  always @(posedge CLK) chain <= SE ? {chain[N-2:0], SI} : ~chain;
  assign SO = chain[N-1];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      misc++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // the pattern is loaded intact, each capture cycle inverts it, unload returns it in PAT bit order
  function automatic logic [N-1:0] model_rsp(input logic [N-1:0] pat);
    logic [N-1:0] v = pat;
    for (int i = 0; i < C; i++) v = ~v;
    return v;
  endfunction

  task automatic run_pat(input logic [N-1:0] pat, input logic [N-1:0] expd,
                         input int hold, input bit abort);
    int w;
    item_t it;
    logic [T-1:0] got_se, got_si, got_busy, exp_se, exp_si;
    w = 0;
    while (!PAT_READY && w < 60) begin
      PAT_VALID = 1'($urandom_range(0, 1));
      PAT_DATA  = N'($urandom);
      @(negedge CLK);
      w++;
    end
    if (!PAT_READY) chk("pat_ready_wait", 1'b0, 1'b1);
    PAT_VALID = 1'b1;
    PAT_DATA  = pat;
    EXP_DATA  = expd;
    @(posedge CLK);
    if (abort) begin
      @(negedge CLK);
      PAT_VALID = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      chk("abort_state", {SE, RSP_VALID, BUSY, ERR_CNT}, '0);
      RST = 1'b0;
      model_err = 0;
      @(negedge CLK);
      chk("abort_ready", PAT_READY, 1'b1);
      return;
    end
    exp_se = '0;
    exp_si = '0;
    for (int k = 0; k < N; k++) begin
      exp_se[k] = 1'b1;
      exp_si[k] = pat[N-1-k];
    end
    for (int k = N + C; k < 2 * N + C; k++) begin
      exp_se[k] = 1'b1;
      exp_si[k] = FILLV;
    end
    for (int k = 0; k < T; k++) begin
      @(negedge CLK);
      got_se[k]   = SE;
      got_si[k]   = SI;
      got_busy[k] = BUSY;
      if (k == 0) begin
        it.rsp  = model_rsp(pat);
        it.mm   = (it.rsp != expd);
        if (it.mm && model_err < ERR_MAX) model_err++;
        it.err  = CW'(model_err);
        it.hold = hold;
        it.t0   = cyc;
        sb.push_back(it);
        n_pushed++;
      end
      PAT_VALID = (k < T - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      PAT_DATA  = N'($urandom);
      EXP_DATA  = N'($urandom);
    end
    chk("se_trace", got_se, exp_se);
    chk("si_trace", got_si & exp_se, exp_si & exp_se);
    chk("busy_trace", got_busy, {T{1'b1}});
  endtask

  // response monitor / consumer
  initial begin
    item_t it;
    forever begin
      @(negedge CLK);
      if (RSP_VALID === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_rsp", 1'b1, 1'b0);
          RSP_READY = 1'b1;
          @(negedge CLK);
          RSP_READY = 1'b0;
        end else begin
          it = sb.pop_front();
          // edges from the acceptance edge through the edge that raises RSP_VALID, both included
          chk("latency", cyc - it.t0 + 1, 2 * N + C + 1);
          chk("rsp_data", RSP_DATA, it.rsp);
          chk("rsp_mismatch", RSP_MISMATCH, it.mm);
          for (int k = 0; k < it.hold; k++) begin
            RSP_READY = 1'b0;
            @(negedge CLK);
            chk("hold_stable", {RSP_VALID, RSP_DATA, RSP_MISMATCH, PAT_READY},
                {1'b1, it.rsp, it.mm, 1'b0});
          end
          RSP_READY = 1'b1;
          @(negedge CLK);
          RSP_READY = 1'b0;
          chk("post_handshake", {RSP_VALID, PAT_READY}, 2'b01);
          chk("err_cnt", ERR_CNT, it.err);
          n_done++;
        end
      end
    end
  end

  initial begin
    logic [N-1:0] p;
    int w;
    RST = 1'b1; PAT_VALID = 1'b0; PAT_DATA = '0; EXP_DATA = '0; RSP_READY = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_state",
        {SE, SI, RSP_VALID, RSP_DATA, RSP_MISMATCH, ERR_CNT, BUSY, PAT_READY}, 16'h0001);
    RST = 1'b0;
    @(negedge CLK);
    run_pat(8'hA5, 8'h5A, 0, 1'b0);
    run_pat(8'hA5, 8'hA5, 2, 1'b0);
    run_pat(8'h81, 8'h7E, 5, 1'b0);
    run_pat(N'($urandom), N'($urandom), 0, 1'b1);
    run_pat(8'h3C, 8'hC3, 1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      p = N'($urandom);
      run_pat(p, model_rsp(p) ^ N'(1 << (i % N)), i % 3, 1'b0);
    end
    for (int i = 0; i < 20; i++) begin
      p = N'($urandom);
      run_pat(p, $urandom_range(0, 1) ? model_rsp(p) : N'($urandom), $urandom_range(0, 3), 1'b0);
    end
    w = 0;
    while ((n_done != n_pushed || !PAT_READY) && w < 100) begin
      @(negedge CLK);
      w++;
    end
    chk("drain", n_done, n_pushed);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

  initial begin
    #300000;
    misc++;
    $display("FAIL watchdog: run did not complete, got timeout, expected completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, misc);
    $finish;
  end

endmodule
